param_accum_cpu: RTL and testbench

- Parametrised next-generation accumulator processor: one accumulator, integrated control unit and datapath, internal program/data memory.
- Adds over the 8-bit/3-bit-opcode machine:
  - generic data and address widths;
  - 4-bit opcode ISA with logic, increment/decrement, OUT and carry-jump instructions;
  - carry flag;
  - host program-load port;
  - start/restart control;
  - edge-qualified Enter handshake.
- Sits at the top of the processor subsystem; driven by switches/host, observed on dataOut.

---
 rtl/param_accum_cpu_if.sv | 28 ++
 rtl/param_accum_cpu.sv | 135 +++++++++++++
 tb/tb_param_accum_cpu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/param_accum_cpu_if.sv
// Host-side bus of the accumulator processor: program load, IN/OUT data and status.
// The host drives through master; the processor core attaches through slave.
interface param_accum_cpu_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] data_in;
    logic              Enter;
    logic              start;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] dataOut;
    logic              out_valid;
    logic              CheckState;
    logic              Halt;
    logic              carry;

    modport master (
        output data_in, Enter, start, prog_we, prog_addr, prog_data,
        input  dataOut, out_valid, CheckState, Halt, carry
    );

    modport slave (
        input  data_in, Enter, start, prog_we, prog_addr, prog_data,
        output dataOut, out_valid, CheckState, Halt, carry
    );
endinterface

// File: rtl/param_accum_cpu.sv
// Parametrised accumulator processor: multi-cycle FETCH/DECODE/EXEC control unit,
// carry flag, internal program/data memory loadable from the host while stopped.
module param_accum_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic             Clock,
    input logic             Reset,
    param_accum_cpu_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [3:0] OP_LDA  = 4'd0,  OP_STA = 4'd1,  OP_ADD  = 4'd2,  OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR  = 4'd5,  OP_IN   = 4'd6,  OP_OUT = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8,  OP_JZ  = 4'd9,  OP_JPOS = 4'd10, OP_JC  = 4'd11;
    localparam logic [3:0] OP_INC  = 4'd12, OP_DEC = 4'd13, OP_NOP  = 4'd14, OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_INWAIT, S_HALTED
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W+3:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] data_out_r;
    logic              c;
    logic              out_valid_r;
    logic              check_r;
    logic              halt_r;
    logic              enter_q;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] addr;

    assign opcode = ir[ADDR_W+3:ADDR_W];
    assign addr   = ir[ADDR_W-1:0];

    // Top bit of the widened result is the carry (add) or borrow (subtract).
    function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic [DATA_W:0] sub_b(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if ((state == S_IDLE || state == S_HALTED) && bus.prog_we)
                mem[bus.prog_addr] <= bus.prog_data;
            else if (state == S_EXEC && opcode == OP_STA)
                mem[addr] <= acc;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            acc         <= '0;
            c           <= 1'b0;
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            enter_q     <= 1'b0;
            check_r     <= 1'b0;
            halt_r      <= 1'b0;
        end else begin
            enter_q     <= bus.Enter;
            out_valid_r <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        acc    <= '0;
                        c      <= 1'b0;
                        halt_r <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[pc][ADDR_W+3:0];
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                // Branch conditions use A and C as they stand here, before any EXEC.
                S_DECODE: begin
                    opnd <= mem[addr];
                    case (opcode)
                        OP_JMP:  begin pc <= addr; state <= S_FETCH; end
                        OP_JZ:   begin if (acc == '0) pc <= addr; state <= S_FETCH; end
                        OP_JPOS: begin if (!acc[DATA_W-1]) pc <= addr; state <= S_FETCH; end
                        OP_JC:   begin if (c) pc <= addr; state <= S_FETCH; end
                        OP_NOP:  state <= S_FETCH;
                        OP_HALT: begin state <= S_HALTED; halt_r <= 1'b1; end
                        OP_IN:   begin state <= S_INWAIT; check_r <= 1'b1; end
                        default: state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LDA:  acc <= opnd;
                        OP_ADD:  {c, acc} <= add_c(acc, opnd);
                        OP_SUB:  {c, acc} <= sub_b(acc, opnd);
                        OP_AND:  acc <= acc & opnd;
                        OP_OR:   acc <= acc | opnd;
                        OP_OUT:  begin data_out_r <= acc; out_valid_r <= 1'b1; end
                        OP_INC:  {c, acc} <= add_c(acc, DATA_W'(1));
                        OP_DEC:  {c, acc} <= sub_b(acc, DATA_W'(1));
                        default: ;
                    endcase
                    state <= S_FETCH;
                end
                S_INWAIT: begin
                    if (bus.Enter && !enter_q) begin
                        acc     <= bus.data_in;
                        check_r <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dataOut    = data_out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.CheckState = check_r;
    assign bus.Halt       = halt_r;
    assign bus.carry      = c;
endmodule

// File: tb/tb_param_accum_cpu.sv
// Bench for param_accum_cpu: directed programs plus random straight-line programs,
// compared against an instruction-level model of the ISA.
module tb_param_accum_cpu;
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    param_accum_cpu_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    param_accum_cpu #(.DATA_W(8), .ADDR_W(4)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    int m [16];
    int in_vals [$];
    int exp_out [$];
    int got_out [$];
    int prog [$];
    int exp_dout = 0;
    int exp_carry, exp_halted, exp_cycles, exp_ins;

    always @(negedge Clock)
        if (bus.out_valid === 1'b1) got_out.push_back(int'(bus.dataOut));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Instruction-level model: runs the program in m from PC=0 with A=C=0.
    task automatic model_run();
        int pc, a, c, k, w, op, ad, d;
        pc = 0; a = 0; c = 0; k = 0;
        exp_out.delete(); exp_cycles = 0; exp_ins = 0; exp_halted = 0;
        for (int n = 0; n < 1000 && exp_halted == 0; n++) begin
            w = m[pc]; op = (w >> 4) & 15; ad = w & 15; pc = (pc + 1) % 16; d = m[ad];
            exp_cycles += 3;
            case (op)
                0: a = d;
                1: m[ad] = a;
                2: begin a = a + d; c = (a > 255) ? 1 : 0; a = a % 256; end
                3: begin c = (a < d) ? 1 : 0; a = (a - d + 256) % 256; end
                4: a = a & d;
                5: a = a | d;
                6: begin if (k < in_vals.size()) a = in_vals[k]; k++; exp_ins++; end
                7: begin exp_out.push_back(a); exp_dout = a; end
                8: begin pc = ad; exp_cycles -= 1; end
                9: begin if (a == 0) pc = ad; exp_cycles -= 1; end
                10: begin if (a < 128) pc = ad; exp_cycles -= 1; end
                11: begin if (c == 1) pc = ad; exp_cycles -= 1; end
                12: begin a = a + 1; c = (a > 255) ? 1 : 0; a = a % 256; end
                13: begin c = (a == 0) ? 1 : 0; a = (a + 255) % 256; end
                14: exp_cycles -= 1;
                default: begin exp_halted = 1; exp_cycles -= 1; end
            endcase
        end
        exp_carry = c;
    endtask

    task automatic load(input int addr, input int data);
        bus.prog_we = 1'b1; bus.prog_addr = 4'(addr); bus.prog_data = 8'(data);
        m[addr] = data;
        @(negedge Clock);
        bus.prog_we = 1'b0;
    endtask

    task automatic load_prog();
        foreach (prog[i]) load(i, prog[i]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
    endtask

    task automatic run(input string tag, input int budget, input bit check_cyc, input bit inject);
        int n, idx, cs_hits;
        bit prev_cs;
        model_run();
        got_out.delete();
        pulse_start();
        n = 0; idx = 0; cs_hits = 0; prev_cs = 1'b0;
        while (bus.Halt !== 1'b1 && n < budget) begin
            if (bus.CheckState === 1'b1 && !prev_cs) cs_hits++;
            prev_cs = (bus.CheckState === 1'b1);
            if (inject && n == 2) begin
                bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = 8'hF0;
            end else bus.prog_we = 1'b0;
            if (bus.Enter) bus.Enter = 1'b0;
            else if (bus.CheckState === 1'b1 && idx < in_vals.size()) begin
                bus.data_in = 8'(in_vals[idx]); idx++; bus.Enter = 1'b1;
            end
            @(negedge Clock);
            n++;
        end
        bus.prog_we = 1'b0; bus.Enter = 1'b0;
        chk({tag, ".halt"}, bus.Halt, 1);
        if (check_cyc) chk({tag, ".cycles"}, n, exp_cycles);
        chk({tag, ".n_out"}, got_out.size(), exp_out.size());
        foreach (exp_out[i]) chk({tag, ".out"}, (i < got_out.size()) ? got_out[i] : -1, exp_out[i]);
        chk({tag, ".carry"}, bus.carry, exp_carry);
        chk({tag, ".dataOut"}, bus.dataOut, exp_dout);
        chk({tag, ".in_waits"}, cs_hits, exp_ins);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        bus.data_in = '0; bus.Enter = 1'b0; bus.start = 1'b0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);
        chk("rst.dataOut", bus.dataOut, 0);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.Halt", bus.Halt, 0);
        chk("rst.CheckState", bus.CheckState, 0);
        chk("rst.carry", bus.carry, 0);

        // Two INs summed: 5 + 7
        prog = '{'h60, 'h1E, 'h60, 'h2E, 'h70, 'hF0};
        load_prog();
        in_vals = '{5, 7};
        run("t1", 200, 1'b0, 1'b0);
        chk("t1.sum", bus.dataOut, 12);

        // Countdown 3,2,1 then restart from HALTED
        in_vals.delete();
        load(15, 3);
        prog = '{'h0F, 'h70, 'hD0, 'h95, 'h81, 'hF0};
        load_prog();
        run("t2", 300, 1'b1, 1'b0);
        chk("t2.last", bus.dataOut, 1);
        run("t2r", 300, 1'b1, 1'b0);

        // Carry jump taken, then not taken
        load(14, 200); load(15, 100);
        prog = '{'h0E, 'h2F, 'hB4, 'hF0, 'h70, 'hF0};
        load_prog();
        run("t3", 200, 1'b1, 1'b0);
        chk("t3.sum", bus.dataOut, 44);
        chk("t3.c", bus.carry, 1);
        load(15, 50);
        run("t3b", 200, 1'b1, 1'b0);
        chk("t3b.c", bus.carry, 0);

        // Enter already high when IN is reached
        prog = '{'h60, 'h70, 'hF0};
        load_prog();
        got_out.delete();
        bus.Enter = 1'b1; bus.data_in = 8'h11;
        pulse_start();
        repeat (8) @(negedge Clock);
        chk("t4.held_wait", bus.CheckState, 1);
        chk("t4.held_nout", got_out.size(), 0);
        bus.Enter = 1'b0;
        @(negedge Clock);
        chk("t4.released", bus.CheckState, 1);
        bus.data_in = 8'h5A; bus.Enter = 1'b1;
        @(negedge Clock);
        chk("t4.captured", bus.CheckState, 0);
        bus.Enter = 1'b0;
        n = 0;
        while (bus.Halt !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
        chk("t4.halt", bus.Halt, 1);
        chk("t4.dataOut", bus.dataOut, 'h5A);
        chk("t4.nout", got_out.size(), 1);
        exp_dout = 'h5A;

        // Reset while waiting for Enter
        pulse_start();
        n = 0;
        while (bus.CheckState !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
        chk("t5.wait", bus.CheckState, 1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        exp_dout = 0;
        chk("t5.CheckState", bus.CheckState, 0);
        chk("t5.Halt", bus.Halt, 0);
        chk("t5.dataOut", bus.dataOut, 0);
        in_vals = '{'h33};
        run("t5b", 100, 1'b0, 1'b0);
        in_vals.delete();

        // prog_we while running is ignored
        load(15, 3);
        prog = '{'h0F, 'h70, 'hD0, 'h95, 'h81, 'hF0};
        load_prog();
        run("t6", 300, 1'b1, 1'b1);
        run("t6r", 300, 1'b1, 1'b0);

        // Random terminating programs: only forward jumps, HALT at 11, stores into 12..15
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 11; a++) begin
                int op, ad;
                do op = $urandom_range(0, 14); while (op == 6);
                if (op >= 8 && op <= 11) ad = $urandom_range(a + 1, 11);
                else if (op == 1) ad = $urandom_range(12, 15);
                else ad = $urandom_range(0, 15);
                load(a, op * 16 + ad);
            end
            load(11, 'hF0);
            for (int a = 12; a < 16; a++) load(a, $urandom_range(0, 255));
            run($sformatf("rnd%0d", r), 300, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
